pulse_period_meter: RTL and testbench
=====================================

Name: pulse_period_meter

Overview:
Receive-side companion to the periodic pulse generator. Measures the number of Clk cycles between consecutive rising edges of a single-clock-domain Pulse input and reports each measurement with a one-cycle Valid strobe. Used to check a pulse generator's divide ratio on the board, and as a tick-rate monitor in front of the counter/display blocks. Tracks lock and stale/overflow status.

Parameters:
CNT_W, 26, width of cycle counter and Period output
MAX_CNT, 2**CNT_W-1, saturation value; no edge by this count means the measurement is stale

Ports:
Clk  input  1  system clock, all logic on posedge
Reset  input  1  synchronous, active-high reset
En  input  1  measurement enable
Pulse  input  1  pulse stream, synchronous to Clk (no synchroniser in this block)
Period  output  CNT_W  last measured edge-to-edge interval in Clk cycles
Valid  output  1  one-cycle strobe: Period updated this cycle
Locked  output  1  high while two or more consecutive edges have been measured without staleness
Overflow  output  1  sticky: interval exceeded MAX_CNT; cleared by next Valid

Behaviour:
- Interface: one clock (Clk); Reset synchronous, active-high; Reset has priority over En and Pulse.
- Reset values: Period=0, Valid=0, Locked=0, Overflow=0, internal Pulse_d=0, Cnt=0, state=IDLE.
- Edge = Pulse & ~Pulse_d, where Pulse_d is Pulse registered every cycle, including when En=0. A Pulse sampled high on the first cycle after reset counts as an edge. Held-high Pulse yields one edge.
- States: IDLE, MEASURE, STALE.
- IDLE: wait for edge; on edge -> MEASURE, Cnt<=1. No Valid.
- MEASURE, no edge: Cnt<=Cnt+1.
  - If Cnt==MAX_CNT: -> STALE, Overflow<=1, Locked<=0, Cnt holds at MAX_CNT.
- MEASURE, edge (edge has priority over the saturation check):
  - Period<=Cnt, Valid<=1 the next cycle, Locked<=1, Overflow<=0, Cnt<=1, stay in MEASURE.
- STALE: Cnt holds. On edge -> MEASURE, Cnt<=1, no Valid (interval unknown). Overflow stays set until the next Valid.
- Latency: edge sampled at cycle t -> Period/Valid visible at cycle t+1. Edges sampled at t0 and t1 give Period=t1-t0.
- Valid is high for exactly one cycle per measurement. Period holds between strobes.
- Back-to-back edges need Pulse low for at least one cycle, so the minimum reportable Period is 2.
- En=0: state->IDLE, Cnt<=0, Valid<=0, Locked<=0. Period and Overflow hold. Re-enable needs two edges before the next Valid.
- Reset mid-measurement: all state returns to reset values. No Valid is issued for the partial interval.

Decomposition:
- Shared include/package: state encodings IDLE=2'd0, MEASURE=2'd1, STALE=2'd2, plus the default CNT_W.
- One natural sub-module: rise_detect (Pulse_d register plus edge output), reusable by other tick consumers.
- Counter and FSM stay in the top module.

Test Plan:
- Reset, En=1, 1-cycle Pulse every 5 cycles -> first Valid after the second edge with Period=5, then Valid every 5 cycles; Locked=1 from the first Valid.
- Pulse held high 3 cycles, period 10 -> Period=10 (one edge per pulse), never 1 or 3.
- CNT_W=4 (MAX_CNT=15), one edge then silence -> after 15 counts Overflow=1, Locked=0, no Valid. Next edge gives no Valid; the following edge 6 cycles later -> Period=6, Valid, Overflow=0.
- CNT_W=4, edges exactly 15 cycles apart -> Period=15, Valid, Overflow stays 0 (edge beats saturation).
- En dropped mid-interval, then restored -> Locked=0, Period holds its old value, no Valid until two new edges; the second gives the correct interval.
- Reset asserted 2 cycles before an expected edge -> all outputs 0, no Valid. Pulse high on the first post-reset cycle counts as an edge (Period reported after the next edge).

Source files
------------

// File: rtl/pulse_period_meter_pkg.sv
// Shared definitions for the pulse period meter: FSM state encodings and
// the default counter width.
package pulse_period_meter_pkg;

  localparam int DEFAULT_CNT_W = 26;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STALE   = 2'd2
  } meter_state_e;

endpackage

// File: rtl/pulse_period_meter_if.sv
// Signal bundle between a pulse source and the period meter. The meter
// takes the slave view; whoever drives En/Pulse and reads results takes
// the master view.
interface pulse_period_meter_if
  import pulse_period_meter_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
);

  logic             En;
  logic             Pulse;
  logic [CNT_W-1:0] Period;
  logic             Valid;
  logic             Locked;
  logic             Overflow;

  modport master (
    output En,
    output Pulse,
    input  Period,
    input  Valid,
    input  Locked,
    input  Overflow
  );

  modport slave (
    input  En,
    input  Pulse,
    output Period,
    output Valid,
    output Locked,
    output Overflow
  );

endinterface

// File: rtl/pulse_period_meter_rise_detect.sv
// Rising-edge detector for a signal already synchronous to Clk. The delayed
// copy is updated every cycle regardless of any enable, so a level that is
// held high produces exactly one edge.
module pulse_period_meter_rise_detect (
  input  logic Clk,
  input  logic Reset,
  input  logic Pulse,
  output logic Rise
);

  logic pulse_d;

  // Register the previous Pulse level; cleared by reset so a high level on
  // the first cycle after reset is seen as an edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pulse_d <= 1'b0;
    end else begin
      pulse_d <= Pulse;
    end
  end

  assign Rise = Pulse & ~pulse_d;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures the number of Clk cycles between consecutive rising edges of
// Pulse, strobing Valid for one cycle with each new Period. Locked tracks an
// unbroken run of measurements; Overflow flags an interval that saturated
// the counter and stays set until the next good measurement.
module pulse_period_meter
  import pulse_period_meter_pkg::*;
#(
  parameter int               CNT_W   = DEFAULT_CNT_W,
  parameter logic [CNT_W-1:0] MAX_CNT = {CNT_W{1'b1}}
) (
  input  logic                 Clk,
  input  logic                 Reset,
  pulse_period_meter_if.slave  bus
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  meter_state_e     state;
  meter_state_e     state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] period_next;
  logic             valid_q;
  logic             valid_next;
  logic             locked_q;
  logic             locked_next;
  logic             overflow_q;
  logic             overflow_next;
  logic             rise;

  pulse_period_meter_rise_detect u_rise_detect (
    .Clk   (Clk),
    .Reset (Reset),
    .Pulse (bus.Pulse),
    .Rise  (rise)
  );

  // State, counter and output registers; reset wins over everything.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      cnt        <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      period_q   <= period_next;
      valid_q    <= valid_next;
      locked_q   <= locked_next;
      overflow_q <= overflow_next;
    end
  end

  // Next-state logic: disabling parks the meter in IDLE, an edge in MEASURE
  // reports the count (edge beats saturation), and an edge leaving STALE
  // only restarts counting because that interval is unknown.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    period_next   = period_q;
    valid_next    = 1'b0;
    locked_next   = locked_q;
    overflow_next = overflow_q;

    if (!bus.En) begin
      state_next  = IDLE;
      cnt_next    = '0;
      locked_next = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rise) begin
            state_next = MEASURE;
            cnt_next   = ONE;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_next   = cnt;
            valid_next    = 1'b1;
            locked_next   = 1'b1;
            overflow_next = 1'b0;
            cnt_next      = ONE;
          end else if (cnt == MAX_CNT) begin
            state_next    = STALE;
            overflow_next = 1'b1;
            locked_next   = 1'b0;
          end else begin
            cnt_next = cnt + ONE;
          end
        end
        STALE: begin
          if (rise) begin
            state_next = MEASURE;
            cnt_next   = ONE;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  assign bus.Period   = period_q;
  assign bus.Valid    = valid_q;
  assign bus.Locked   = locked_q;
  assign bus.Overflow = overflow_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed bench for pulse_period_meter. Two meters share the same stimulus:
// one at the default width and one at CNT_W=4 so saturation is reachable.
module tb_pulse_period_meter;

  logic Clk;
  logic Reset;
  logic en;
  logic pulse;
  int   vectors;
  int   miscompares;

  pulse_period_meter_if                ifa ();
  pulse_period_meter_if #(.CNT_W(4))   ifb ();

  assign ifa.En    = en;
  assign ifa.Pulse = pulse;
  assign ifb.En    = en;
  assign ifb.Pulse = pulse;

  pulse_period_meter dut_a (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (ifa)
  );

  pulse_period_meter #(.CNT_W(4)) dut_b (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (ifb)
  );

  // Free-running clock.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Present a Pulse level, let one rising edge sample it, then settle.
  task automatic tick(input logic p);
    pulse = p;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Check all four outputs of both meters against the same expectation.
  task automatic check_both(input string tag, input logic [31:0] period,
                            input logic valid, input logic locked, input logic ovf);
    check({tag, "_a_period"}, 32'(ifa.Period), period);
    check({tag, "_a_valid"}, 32'(ifa.Valid), 32'(valid));
    check({tag, "_a_locked"}, 32'(ifa.Locked), 32'(locked));
    check({tag, "_a_ovf"}, 32'(ifa.Overflow), 32'(ovf));
    check({tag, "_b_period"}, 32'(ifb.Period), period);
    check({tag, "_b_valid"}, 32'(ifb.Valid), 32'(valid));
    check({tag, "_b_locked"}, 32'(ifb.Locked), 32'(locked));
    check({tag, "_b_ovf"}, 32'(ifb.Overflow), 32'(ovf));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    Reset       = 1'b1;
    en          = 1'b0;
    pulse       = 1'b0;

    // Reset state.
    idle(2);
    check_both("reset", 0, 0, 0, 0);
    Reset = 1'b0;
    en    = 1'b1;

    // One-cycle pulse every 5 cycles.
    tick(1'b1);
    check_both("first_edge", 0, 0, 0, 0);
    idle(4);
    check_both("before_2nd", 0, 0, 0, 0);
    tick(1'b1);
    check_both("p5_first", 5, 1, 1, 0);
    tick(1'b0);
    check_both("p5_strobe_end", 5, 0, 1, 0);
    idle(3);
    tick(1'b1);
    check_both("p5_second", 5, 1, 1, 0);

    // Pulse held high 3 cycles, period 10: one edge per pulse.
    idle(4);
    tick(1'b1);
    check_both("held_entry", 5, 1, 1, 0);
    tick(1'b1);
    tick(1'b1);
    check_both("held_high", 5, 0, 1, 0);
    idle(7);
    tick(1'b1);
    check_both("p10_first", 10, 1, 1, 0);
    tick(1'b1);
    tick(1'b1);
    idle(7);
    tick(1'b1);
    check_both("p10_second", 10, 1, 1, 0);

    // Silence: the 4-bit meter saturates, the wide one keeps counting.
    idle(14);
    check("sat_pre_b_ovf", 32'(ifb.Overflow), 0);
    check("sat_pre_b_locked", 32'(ifb.Locked), 1);
    tick(1'b0);
    check("sat_b_ovf", 32'(ifb.Overflow), 1);
    check("sat_b_locked", 32'(ifb.Locked), 0);
    check("sat_b_valid", 32'(ifb.Valid), 0);
    check("sat_a_locked", 32'(ifa.Locked), 1);
    check("sat_a_ovf", 32'(ifa.Overflow), 0);
    idle(3);
    tick(1'b1);
    check("stale_exit_b_valid", 32'(ifb.Valid), 0);
    check("stale_exit_b_ovf", 32'(ifb.Overflow), 1);
    check("stale_exit_b_period", 32'(ifb.Period), 10);
    check("long_a_period", 32'(ifa.Period), 19);
    check("long_a_valid", 32'(ifa.Valid), 1);
    idle(5);
    tick(1'b1);
    check_both("after_stale_p6", 6, 1, 1, 0);

    // Edges exactly MAX_CNT apart on the 4-bit meter: the edge wins.
    idle(14);
    check("p15_pre_b_ovf", 32'(ifb.Overflow), 0);
    tick(1'b1);
    check_both("p15", 15, 1, 1, 0);

    // Disable mid-interval, then re-enable: two new edges needed.
    idle(3);
    en = 1'b0;
    tick(1'b0);
    check_both("disabled", 15, 0, 0, 0);
    idle(2);
    en = 1'b1;
    tick(1'b1);
    check_both("reen_first_edge", 15, 0, 0, 0);
    idle(6);
    tick(1'b1);
    check_both("reen_p7", 7, 1, 1, 0);

    // Reset two cycles before the expected edge, Pulse high through reset.
    idle(4);
    Reset = 1'b1;
    tick(1'b1);
    check_both("mid_reset", 0, 0, 0, 0);
    Reset = 1'b0;
    tick(1'b1);
    check_both("post_reset_edge", 0, 0, 0, 0);
    idle(3);
    tick(1'b1);
    check_both("post_reset_p4", 4, 1, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
